// File: rtl/int_controller.sv
// int_controller: IF (FF0F) / IE (FFFF) interrupt registers with source edge detection and per-source request outputs.
// Optional build macro INT_CTRL_SRC_SYNC_EN adds a two-flop synchronizer on every source line before edge detection.
module int_controller #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic        clk4_2,
    input  logic        reset_n,
    input  logic [15:0] address_bus,
    input  logic [7:0]  data_bus_in,
    input  logic        mem_we,
    output logic [7:0]  data_out,
    output logic        data_out_sel,
    input  logic        v_blank_src,
    input  logic        lcd_stat_src,
    input  logic        timer_src,
    input  logic        serial_src,
    input  logic        joypad_src,
    input  logic        cpu_v_blank_int_clear,
    input  logic        cpu_lcd_stat_int_clear,
    input  logic        cpu_timer_int_clear,
    input  logic        cpu_serial_int_clear,
    input  logic        cpu_joypad_int_clear,
    output logic        v_blank_int_req,
    output logic        lcd_stat_int_req,
    output logic        timer_int_req,
    output logic        serial_int_req,
    output logic        joypad_int_req,
    output logic        int_pending
);

    logic [4:0] src_raw, src_in, clr, edge_v, req;
    logic [4:0] src_q, src_d, if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic       if_sel, ie_sel;

    assign src_raw = {joypad_src, serial_src, timer_src, lcd_stat_src, v_blank_src};
    assign clr     = {cpu_joypad_int_clear, cpu_serial_int_clear, cpu_timer_int_clear,
                      cpu_lcd_stat_int_clear, cpu_v_blank_int_clear};

`ifdef INT_CTRL_SRC_SYNC_EN
    logic [4:0] meta_q, meta_d, sync_q, sync_d;

    // Synchronizer next state: raw lines into the first stage, first stage into the second
    always_comb begin
        meta_d = src_raw;
        sync_d = meta_q;
    end

    // Two-flop synchronizer for asynchronous sources (pins, other clock domains)
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign src_in = sync_q;
`else
    assign src_in = src_raw;
`endif

    assign if_sel = (address_bus == IF_ADDR);
    assign ie_sel = (address_bus == IE_ADDR);

    // Next state: edge set beats CPU clear, which beats a bus write, which beats hold
    always_comb begin
        src_d  = src_in;
        edge_v = src_in & ~src_q;
        if_d   = ((mem_we && if_sel ? data_bus_in[4:0] : if_q) & ~clr) | edge_v;
        ie_d   = mem_we && ie_sel ? data_bus_in : ie_q;
    end

    // State registers; reset clears everything without waiting for the clock
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            if_q  <= '0;
            ie_q  <= '0;
        end else begin
            src_q <= src_d;
            if_q  <= if_d;
            ie_q  <= ie_d;
        end
    end

    assign req          = if_q & ie_q[4:0];
    assign int_pending  = |req;
    assign data_out_sel = if_sel | ie_sel;
    assign data_out     = if_sel ? {3'b111, if_q} : ie_sel ? ie_q : 8'h00;

    assign {joypad_int_req, serial_int_req, timer_int_req, lcd_stat_int_req, v_blank_int_req} = req;

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed and randomized checks of int_controller against a per-bit behavioural model.
module tb_int_controller;

    logic        clk4_2 = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] address_bus = 16'hFF0F;
    logic [7:0]  data_bus_in = 8'h00;
    logic        mem_we = 1'b0;
    logic [4:0]  src = '0;
    logic [4:0]  clr = '0;
    logic [7:0]  data_out;
    logic        data_out_sel;
    logic        v_blank_int_req, lcd_stat_int_req, timer_int_req, serial_int_req, joypad_int_req;
    logic        int_pending;

    int checks = 0;
    int failures = 0;

`ifdef INT_CTRL_SRC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    // Behavioural model: IF/IE contents, last source level seen by edge detection, sync pipeline
    logic [4:0] m_if = '0, m_prev = '0, m_s1 = '0, m_s2 = '0;
    logic [7:0] m_ie = '0;

    int_controller dut (
        .clk4_2(clk4_2), .reset_n(reset_n), .address_bus(address_bus), .data_bus_in(data_bus_in),
        .mem_we(mem_we), .data_out(data_out), .data_out_sel(data_out_sel),
        .v_blank_src(src[0]), .lcd_stat_src(src[1]), .timer_src(src[2]), .serial_src(src[3]), .joypad_src(src[4]),
        .cpu_v_blank_int_clear(clr[0]), .cpu_lcd_stat_int_clear(clr[1]), .cpu_timer_int_clear(clr[2]),
        .cpu_serial_int_clear(clr[3]), .cpu_joypad_int_clear(clr[4]),
        .v_blank_int_req(v_blank_int_req), .lcd_stat_int_req(lcd_stat_int_req), .timer_int_req(timer_int_req),
        .serial_int_req(serial_int_req), .joypad_int_req(joypad_int_req), .int_pending(int_pending)
    );

    always #5 clk4_2 = ~clk4_2;

    function automatic logic [4:0] reqs();
        return {joypad_int_req, serial_int_req, timer_int_req, lcd_stat_int_req, v_blank_int_req};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_if = '0; m_ie = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    endtask

    // One clock: apply the spec's per-bit rules to the inputs present at the edge, then settle
    task automatic cycle();
        logic [4:0] det;
        @(posedge clk4_2);
`ifdef INT_CTRL_SRC_SYNC_EN
        det = m_s2; m_s2 = m_s1; m_s1 = src;
`else
        det = src;
`endif
        for (int n = 0; n < 5; n++) begin
            if (det[n] && !m_prev[n]) m_if[n] = 1'b1;
            else if (clr[n]) m_if[n] = 1'b0;
            else if (mem_we && address_bus == 16'hFF0F) m_if[n] = data_bus_in[n];
        end
        if (mem_we && address_bus == 16'hFFFF) m_ie = data_bus_in;
        m_prev = det;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_d;
        logic [4:0] exp_r;
        exp_d = address_bus == 16'hFF0F ? {3'b111, m_if} : address_bus == 16'hFFFF ? m_ie : 8'h00;
        exp_r = m_if & m_ie[4:0];
        chk({tag, " data_out"}, data_out, exp_d);
        chk({tag, " sel"}, {7'd0, data_out_sel}, {7'd0, address_bus == 16'hFF0F || address_bus == 16'hFFFF});
        chk({tag, " reqs"}, {3'd0, reqs()}, {3'd0, exp_r});
        chk({tag, " pending"}, {7'd0, int_pending}, {7'd0, |exp_r});
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        address_bus = a; data_bus_in = d; mem_we = 1'b1;
        cycle();
        mem_we = 1'b0;
        check_model("write");
    endtask

    task automatic read(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address_bus = a; #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        // Reset state reads
        #1;
        read("rst IF", 16'hFF0F, 8'hE0);
        chk("rst IF sel", {7'd0, data_out_sel}, 8'h01);
        read("rst IE", 16'hFFFF, 8'h00);
        chk("rst IE sel", {7'd0, data_out_sel}, 8'h01);
        read("rst other", 16'hFF10, 8'h00);
        chk("rst other sel", {7'd0, data_out_sel}, 8'h00);
        chk("rst pending", {7'd0, int_pending}, 8'h00);
        @(negedge clk4_2);
        reset_n = 1'b1;

        // Enable v_blank and timer, then hold timer high
        write(16'hFFFF, 8'h05);
        read("IE readback", 16'hFFFF, 8'h05);
        address_bus = 16'hFF0F;
        src[2] = 1'b1;
        for (int i = 0; i < LAT; i++) begin cycle(); check_model("timer lat"); end
        chk("timer IF", data_out, 8'hE4);
        chk("timer req", {7'd0, timer_int_req}, 8'h01);
        chk("timer pending", {7'd0, int_pending}, 8'h01);
        clr[2] = 1'b1; cycle(); clr[2] = 1'b0;
        chk("timer cleared", data_out, 8'hE0);
        cycle(); cycle();
        chk("held no reset", data_out, 8'hE0);
        src[2] = 1'b0;
        src[0] = 1'b1;
        for (int i = 0; i < LAT; i++) cycle();
        chk("vblank req", {7'd0, v_blank_int_req}, 8'h01);
        src[0] = 1'b0;
        for (int i = 0; i < LAT; i++) cycle();

        // IF set but nothing enabled: no pending; then clear timer
        write(16'hFFFF, 8'h00);
        write(16'hFF0F, 8'h04);
        chk("IE0 pending", {7'd0, int_pending}, 8'h00);
        clr[2] = 1'b1; cycle(); clr[2] = 1'b0;
        read("clr timer IF", 16'hFF0F, 8'hE0);

        // Edge beats clear and write on the same bit in the same edge
        src[3] = 1'b1;
        for (int i = 0; i < LAT - 1; i++) cycle();
        clr[3] = 1'b1; data_bus_in = 8'h00; mem_we = 1'b1;
        cycle();
        clr[3] = 1'b0; mem_we = 1'b0; src[3] = 1'b0;
        chk("edge wins", data_out, 8'hE8);
        check_model("edge wins");

        write(16'hFF0F, 8'hFF);
        read("IF FF", 16'hFF0F, 8'hFF);
        write(16'hFF0F, 8'h00);
        read("IF 00", 16'hFF0F, 8'hE0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: address_bus = 16'hFF0F;
                1: address_bus = 16'hFFFF;
                2: address_bus = 16'hFF10;
                default: address_bus = 16'($urandom);
            endcase
            data_bus_in = 8'($urandom);
            mem_we = ($urandom_range(0, 3) == 0);
            src = src ^ (5'($urandom) & 5'($urandom));
            clr = 5'($urandom) & 5'($urandom) & 5'($urandom);
            cycle();
            check_model("rand");
        end
        mem_we = 1'b0; clr = '0; src = '0;
        for (int i = 0; i < LAT; i++) cycle();

        // Asynchronous reset mid-cycle with everything pending
        write(16'hFF0F, 8'h1F);
        write(16'hFFFF, 8'hFF);
        chk("pre-rst reqs", {3'd0, reqs()}, 8'h1F);
        @(posedge clk4_2);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async reqs", {3'd0, reqs()}, 8'h00);
        chk("async pending", {7'd0, int_pending}, 8'h00);
        read("async IE", 16'hFFFF, 8'h00);
        read("async IF", 16'hFF0F, 8'hE0);
        @(negedge clk4_2);
        reset_n = 1'b1;
        cycle();
        check_model("post-rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
